// File: rtl/data_ram_bridge_if.sv
// data_ram_bridge_if: request/acknowledge memory bus between the bridge and a word-wide memory.
// master (bridge): drives mem_req_o, mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o.
// slave (memory): drives mem_ack_i (one cycle per request) and mem_rdata_i.
interface data_ram_bridge_if;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_wdata_o;
  logic        mem_ack_i;
  logic [31:0] mem_rdata_i;
  modport master (
    output mem_req_o, mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o,
    input  mem_ack_i, mem_rdata_i
  );
  modport slave (
    input  mem_req_o, mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o,
    output mem_ack_i, mem_rdata_i
  );
endinterface

// File: rtl/data_ram_bridge.sv
// data_ram_bridge: turns a CPU load/store with pipeline stall into one memory request, with timeout.
// clk/rst: clock and asynchronous active-low reset.
// ram_*: CPU access request, store data and stall; ram_data_o returns the aligned load word.
// mem: memory bus master side; bus_err_o: sticky timeout flag cleared only by reset.
module data_ram_bridge #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ram_en,
  input  logic        ram_write_en,
  input  logic [31:0] ram_addr,
  input  logic [3:0]  ram_select,
  input  logic [31:0] ram_data_i,
  output logic [31:0] ram_data_o,
  output logic        ram_stall_o,
  data_ram_bridge_if.master mem,
  output logic        bus_err_o
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state, next_state;
  logic        lat_we;
  logic [31:0] lat_addr;
  logic [3:0]  lat_sel;
  logic [31:0] lat_data;
  logic [15:0] wait_cnt;
  logic        zero_store;
  logic        timed_out;
  logic        busy;
  // A store with no lanes enabled has nothing to write, so it skips the memory entirely.
  assign zero_store = ram_write_en && ram_select == 4'b0000;
  assign timed_out  = !mem.mem_ack_i && wait_cnt == 16'(TIMEOUT - 1);
  assign busy       = state == BUSY;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else state <= next_state;
  end
  // DONE never samples ram_en, so a request still held by the CPU is not re-issued.
  always_comb begin
    next_state = state == IDLE ? (ram_en ? (zero_store ? DONE : BUSY) : IDLE) :
                 state == BUSY ? ((mem.mem_ack_i || timed_out) ? DONE : BUSY) : IDLE;
  end
  // Bus outputs are gated by BUSY so they fall to zero as soon as reset forces IDLE.
  always_comb begin
    ram_stall_o     = (state == IDLE && ram_en) || busy;
    mem.mem_req_o   = busy;
    mem.mem_we_o    = busy && lat_we;
    mem.mem_addr_o  = busy ? lat_addr & ~32'h3 : '0;
    mem.mem_be_o    = busy ? lat_sel : '0;
    mem.mem_wdata_o = busy ? lat_data : '0;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lat_we     <= 1'b0;
      lat_addr   <= '0;
      lat_sel    <= '0;
      lat_data   <= '0;
      wait_cnt   <= '0;
      ram_data_o <= '0;
      bus_err_o  <= 1'b0;
    end else begin
      if (state == IDLE && ram_en) begin
        lat_we   <= ram_write_en;
        lat_addr <= ram_addr;
        lat_sel  <= ram_select;
        lat_data <= ram_data_i;
        wait_cnt <= '0;
      end
      if (busy) begin
        if (mem.mem_ack_i) begin
          if (!lat_we) ram_data_o <= mem.mem_rdata_i;
        end else if (timed_out) begin
          bus_err_o <= 1'b1;
          if (!lat_we) ram_data_o <= '0;
        end else begin
          wait_cnt <= wait_cnt + 16'd1;
        end
      end
    end
  end
endmodule
